pin_keypad_tx: RTL and testbench

- Driver-side PIN entry terminal. Collects BCD digit keypresses and transmits a 4-digit PIN to the gate access controller.
- Sends the PIN as clave_ingresada with a one-cycle clave_valida strobe.
- Reacts to the controller's verdict signals: abriendo_compuerta, alarm_pin_incorrecto, alarm_bloqueo.
- Sits between the keypad scanner/debouncer and the gate access controller.

---
 rtl/pin_keypad_if.sv | 30 +++
 rtl/pin_keypad_tx.sv | 119 +++++++++++
 tb/tb_pin_keypad_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pin_keypad_if.sv
// Handshake bundle between the keypad scanner, the PIN terminal and the gate controller.
interface pin_keypad_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        llegado_vehiculo;
  logic        abriendo_compuerta;
  logic        alarm_pin_incorrecto;
  logic        alarm_bloqueo;
  logic [15:0] clave_ingresada;
  logic        clave_valida;
  logic [2:0]  digit_count;
  logic        key_reject;
  logic        error_timeout;
  logic        teclado_bloqueado;
  logic [1:0]  estado;

  modport master (
    input  key_valid, key_code, llegado_vehiculo,
           abriendo_compuerta, alarm_pin_incorrecto, alarm_bloqueo,
    output clave_ingresada, clave_valida, digit_count, key_reject,
           error_timeout, teclado_bloqueado, estado
  );

  modport slave (
    output key_valid, key_code, llegado_vehiculo,
           abriendo_compuerta, alarm_pin_incorrecto, alarm_bloqueo,
    input  clave_ingresada, clave_valida, digit_count, key_reject,
           error_timeout, teclado_bloqueado, estado
  );
endinterface

// File: rtl/pin_keypad_tx.sv
// Driver-side PIN terminal: assembles 4 BCD digits from keypresses, sends them to the
// gate controller and follows its verdict / lockout signals.
module pin_keypad_tx #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input logic          clk,
  input logic          reset,
  pin_keypad_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, ENTRY = 2'b01, WAIT = 2'b10, LOCKED = 2'b11} state_t;

  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           st;
  logic [CNT_W-1:0] timer;
  logic [15:0]      clave;
  logic [2:0]       cnt;

  assign bus.estado          = st;
  assign bus.clave_ingresada = clave;
  assign bus.digit_count     = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st                    <= IDLE;
      timer                 <= '0;
      clave                 <= '0;
      cnt                   <= '0;
      bus.clave_valida      <= 1'b0;
      bus.key_reject        <= 1'b0;
      bus.error_timeout     <= 1'b0;
      bus.teclado_bloqueado <= 1'b0;
    end else begin
      bus.clave_valida      <= 1'b0;
      bus.key_reject        <= 1'b0;
      bus.error_timeout     <= 1'b0;
      bus.teclado_bloqueado <= 1'b0;
      // Lockout beats everything else, including a key arriving the same cycle.
      if (bus.alarm_bloqueo) begin
        st                    <= LOCKED;
        clave                 <= '0;
        cnt                   <= '0;
        timer                 <= '0;
        bus.key_reject        <= bus.key_valid;
        bus.teclado_bloqueado <= 1'b1;
      end else begin
        case (st)
          IDLE: begin
            bus.key_reject <= bus.key_valid;
            if (bus.llegado_vehiculo) begin
              st    <= ENTRY;
              clave <= '0;
              cnt   <= '0;
              timer <= '0;
            end
          end
          ENTRY: begin
            if (bus.key_valid) begin
              // Any key, even a rejected one, restarts the inactivity timer.
              timer <= '0;
              if (bus.key_code <= 4'h9) begin
                if (cnt < 3'd4) begin
                  clave <= {clave[11:0], bus.key_code};
                  cnt   <= cnt + 3'd1;
                end else bus.key_reject <= 1'b1;
              end else if (bus.key_code == 4'hA) begin
                if (cnt != 3'd0) begin
                  clave <= {4'h0, clave[15:4]};
                  cnt   <= cnt - 3'd1;
                end else bus.key_reject <= 1'b1;
              end else if (bus.key_code == 4'hC) begin
                clave <= '0;
                cnt   <= '0;
              end else if (bus.key_code == 4'hB) begin
                if (cnt == 3'd4) begin
                  st               <= WAIT;
                  bus.clave_valida <= 1'b1;
                end else bus.key_reject <= 1'b1;
              end else bus.key_reject <= 1'b1;
            end else if (timer == T_LAST) begin
              bus.error_timeout <= 1'b1;
              st                <= IDLE;
              clave             <= '0;
              cnt               <= '0;
              timer             <= '0;
            end else timer <= timer + 1'b1;
          end
          WAIT: begin
            bus.key_reject <= bus.key_valid;
            if (bus.abriendo_compuerta) begin
              st    <= IDLE;
              clave <= '0;
              cnt   <= '0;
              timer <= '0;
            end else if (bus.alarm_pin_incorrecto) begin
              st    <= ENTRY;
              clave <= '0;
              cnt   <= '0;
              timer <= '0;
            end else if (timer == T_LAST) begin
              bus.error_timeout <= 1'b1;
              st                <= ENTRY;
              clave             <= '0;
              cnt               <= '0;
              timer             <= '0;
            end else timer <= timer + 1'b1;
          end
          LOCKED: begin
            bus.key_reject <= bus.key_valid;
            st             <= IDLE;
            timer          <= '0;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pin_keypad_tx.sv
// Bench for pin_keypad_tx: directed plan plus random traffic, every cycle compared
// against a digit-queue model of the terminal.
module tb_pin_keypad_tx;
  localparam int T = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pin_keypad_if bus();
  pin_keypad_tx #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: mode 0 idle, 1 entry, 2 waiting for verdict, 3 locked; digits kept as a queue.
  int   m_mode, m_idle;
  int   q[$];
  logic m_cv, m_rej, m_to;

  function automatic logic [15:0] pin_of();
    logic [15:0] v = 0;
    foreach (q[i]) v = v * 16 + 16'(q[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idle = 0; q.delete(); m_cv = 0; m_rej = 0; m_to = 0;
  endtask

  task automatic model_step();
    logic kv = bus.key_valid;
    int   kc = int'(bus.key_code);
    m_cv = 0; m_rej = 0; m_to = 0;
    if (bus.alarm_bloqueo) begin
      m_mode = 3; q.delete(); m_idle = 0; m_rej = kv;
    end else if (m_mode == 0) begin
      m_rej = kv;
      if (bus.llegado_vehiculo) begin m_mode = 1; q.delete(); m_idle = 0; end
    end else if (m_mode == 1) begin
      if (kv) begin
        m_idle = 0;
        if (kc <= 9) begin if (q.size() < 4) q.push_back(kc); else m_rej = 1; end
        else if (kc == 10) begin if (q.size() > 0) void'(q.pop_back()); else m_rej = 1; end
        else if (kc == 12) q.delete();
        else if (kc == 11) begin if (q.size() == 4) begin m_mode = 2; m_cv = 1; end else m_rej = 1; end
        else m_rej = 1;
      end else begin
        m_idle++;
        if (m_idle == T) begin m_to = 1; m_mode = 0; q.delete(); m_idle = 0; end
      end
    end else if (m_mode == 2) begin
      m_rej = kv;
      if (bus.abriendo_compuerta) begin m_mode = 0; q.delete(); m_idle = 0; end
      else if (bus.alarm_pin_incorrecto) begin m_mode = 1; q.delete(); m_idle = 0; end
      else begin
        m_idle++;
        if (m_idle == T) begin m_to = 1; m_mode = 1; q.delete(); m_idle = 0; end
      end
    end else begin
      m_rej = kv; m_mode = 0; m_idle = 0;
    end
  endtask

  function automatic logic [31:0] outs();
    return {7'd0, bus.clave_ingresada, bus.clave_valida, bus.digit_count, bus.key_reject,
            bus.error_timeout, bus.teclado_bloqueado, bus.estado};
  endfunction

  function automatic logic [31:0] exp_outs();
    return {7'd0, pin_of(), m_cv, 3'(q.size()), m_rej, m_to, logic'(m_mode == 3), 2'(m_mode)};
  endfunction

  task automatic cyc(input logic kv, input logic [3:0] kc);
    bus.key_valid = kv; bus.key_code = kc;
    @(posedge clk);
    model_step();
    #1 chk("cycle", outs(), exp_outs());
  endtask

  task automatic key(input logic [3:0] kc); cyc(1'b1, kc); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(1'b0, 4'h0); endtask

  task automatic verdicts(input logic ab, input logic pin, input logic bl);
    bus.abriendo_compuerta = ab; bus.alarm_pin_incorrecto = pin; bus.alarm_bloqueo = bl;
  endtask

  initial begin
    reset = 1'b1;
    bus.key_valid = 0; bus.key_code = 0; bus.llegado_vehiculo = 0;
    verdicts(0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk("reset_state", outs(), 32'd0);
    reset = 1'b0;
    idle(2);

    // Basic PIN 1194 and acceptance
    bus.llegado_vehiculo = 1;
    idle(1);
    key(4'h1); key(4'h1); key(4'h9); key(4'h4);
    key(4'hB);
    chk("pin_1194", {16'd0, bus.clave_ingresada}, 32'h1194);
    chk("estado_wait", {30'd0, bus.estado}, 32'd2);
    idle(2);
    chk("valid_one_cycle", {31'd0, bus.clave_valida}, 32'd0);
    verdicts(1, 0, 0); idle(1); verdicts(0, 0, 0);
    chk("open_to_idle", {30'd0, bus.estado}, 32'd0);
    idle(1);

    // Editing keys
    key(4'h1); key(4'h2); key(4'hA); key(4'h9);
    chk("backspace_pin", {16'd0, bus.clave_ingresada}, 32'h0019);
    key(4'hC); key(4'hA);
    chk("bksp_empty_rej", {31'd0, bus.key_reject}, 32'd1);

    // Rejections: short enter, 5th digit, invalid code
    key(4'h1); key(4'h2); key(4'h3); key(4'hB);
    key(4'h4); key(4'h5);
    chk("fifth_digit", {16'd0, bus.clave_ingresada}, 32'h1234);
    key(4'hE);

    // Wrong PIN, then lockout overriding a simultaneous accept
    key(4'hB);
    verdicts(0, 1, 0); idle(1); verdicts(0, 0, 0);
    chk("wrong_pin", {30'd0, bus.estado}, 32'd1);
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hB);
    verdicts(1, 0, 1); idle(1); verdicts(0, 0, 1);
    chk("locked", {31'd0, bus.teclado_bloqueado}, 32'd1);
    key(4'h5); idle(2);
    verdicts(0, 0, 0); idle(1);
    chk("unlock_idle", {30'd0, bus.estado}, 32'd0);

    // Timeouts in ENTRY and WAIT
    idle(1);
    key(4'h7); key(4'h8);
    idle(T + 1);
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hB);
    idle(T + 2);
    chk("wait_timeout_entry", {30'd0, bus.estado}, 32'd1);

    // Asynchronous reset mid-entry
    key(4'h3); key(4'h5); key(4'h6);
    #2 reset = 1'b1;
    #1 chk("async_reset", outs(), 32'd0);
    model_reset();
    @(posedge clk); #1 chk("reset_hold", outs(), 32'd0);
    reset = 1'b0;
    idle(1);
    key(4'h9); key(4'h8); key(4'h7); key(4'h6); key(4'hB);
    chk("after_reset_pin", {16'd0, bus.clave_ingresada}, 32'h9876);
    verdicts(1, 0, 0); idle(1); verdicts(0, 0, 0);

    // Random traffic in segments with varied key density
    for (int s = 0; s < 200; s++) begin
      int len  = $urandom_range(1, 30);
      int dens = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 30 : 80);
      for (int i = 0; i < len; i++) begin
        int r = $urandom_range(0, 99);
        logic [3:0] kc;
        if (r < 60) kc = 4'($urandom_range(0, 9));
        else if (r < 75) kc = 4'hB;
        else if (r < 85) kc = 4'hA;
        else if (r < 92) kc = 4'hC;
        else kc = 4'($urandom_range(13, 15));
        bus.llegado_vehiculo = ($urandom_range(0, 9) < 6);
        verdicts($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5,
                 bus.alarm_bloqueo ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 199) == 0));
        cyc($urandom_range(0, 99) < dens, kc);
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
